// File: rtl/fsk_mod_pkg.sv
// fsk_mod_pkg: shared widths, FSM states and default tones for the FSK phase modulator.
package fsk_mod_pkg;
  localparam int PHASE_W = 32;
  localparam int DATA_W = 8;
  localparam int SPS_W = 16;
  localparam logic [PHASE_W-1:0] FSK_PHI_F0 = 32'h0CCC_CCCD;
  localparam logic [PHASE_W-1:0] FSK_PHI_F1 = 32'h1999_999A;
  localparam logic [PHASE_W-1:0] FSK_PHI_IDLE = 32'h4000_0000;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/fsk_phase_mod_if.sv
// fsk_phase_mod_if: valid/ready byte stream feeding the FSK modulator.
interface fsk_phase_mod_if import fsk_mod_pkg::*; #(parameter int DW = DATA_W);
  logic [DW-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, in_valid, input in_ready);
  modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/fsk_bit_timer.sv
// fsk_bit_timer: per-bit sample counter with loadable samples-per-bit (0 treated as 1).
module fsk_bit_timer #(parameter int SPS_W = fsk_mod_pkg::SPS_W) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             clr,
  input  logic             run,
  input  logic [SPS_W-1:0] sps,
  output logic             last
);
  logic [SPS_W-1:0] cnt, sps_eff;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      sps_eff <= SPS_W'(1);
    end else begin
      if (ld) sps_eff <= (sps == '0) ? SPS_W'(1) : sps;
      cnt <= clr ? '0 : run ? cnt + 1'b1 : cnt;
    end
  end
  assign last = cnt == sps_eff - 1'b1;
endmodule

// File: rtl/fsk_phase_mod.sv
// fsk_phase_mod: serializes bytes MSB first into mark/space phase increments for the NCO.
// Optional differential encoding when FSK_DIFF_ENC_EN is defined.
module fsk_phase_mod import fsk_mod_pkg::*; #(
  parameter int PHASE_W = fsk_mod_pkg::PHASE_W,
  parameter int DATA_W = fsk_mod_pkg::DATA_W,
  parameter int SPS_W = fsk_mod_pkg::SPS_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SPS_W-1:0]   sps,
  input  logic [PHASE_W-1:0] phi_f0,
  input  logic [PHASE_W-1:0] phi_f1,
  input  logic [PHASE_W-1:0] phi_idle,
  fsk_phase_mod_if.slave     bus,
  output logic [PHASE_W-1:0] phi_inc_o,
  output logic               tx_active,
  output logic               bit_strobe
);
  localparam int BW = $clog2(DATA_W);
  state_t state, state_n;
  logic alive, last, bit_last, step, accept, dbit, tbit;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] sreg;
  logic [PHASE_W-1:0] f0_q, f1_q, tone;
  fsk_bit_timer #(.SPS_W(SPS_W)) u_timer (
    .clk(clk), .reset_n(reset_n), .ld(accept), .clr(accept || step),
    .run(state == SEND), .sps(sps), .last(last)
  );
  // alive keeps in_ready low for the reset cycle itself
  assign bit_last = state == SEND && last;
  assign step = bit_last && bit_cnt != '0;
  assign bus.in_ready = alive && (state == IDLE || (bit_last && bit_cnt == '0));
  assign accept = bus.in_valid && bus.in_ready;
  assign tx_active = state == SEND;
  assign dbit = accept ? bus.in_data[DATA_W-1] : sreg[DATA_W-1];
`ifdef FSK_DIFF_ENC_EN
  logic prev;
  assign tbit = dbit ^ prev;
  always_ff @(posedge clk) begin
    if (!reset_n) prev <= 1'b0;
    else if (accept || step) prev <= tbit;
    else if (state_n == IDLE) prev <= 1'b0;
  end
`else
  assign tbit = dbit;
`endif
  always_comb begin
    tone = accept ? (tbit ? phi_f1 : phi_f0) : (tbit ? f1_q : f0_q);
    state_n = accept ? SEND : (bit_last && bit_cnt == '0) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alive <= 1'b0;
      bit_strobe <= 1'b0;
      bit_cnt <= '0;
      sreg <= '0;
      f0_q <= '0;
      f1_q <= '0;
      phi_inc_o <= '0;
    end else begin
      alive <= 1'b1;
      bit_strobe <= accept || step;
      if (accept) begin
        sreg <= {bus.in_data[DATA_W-2:0], 1'b0};
        bit_cnt <= BW'(DATA_W - 1);
        f0_q <= phi_f0;
        f1_q <= phi_f1;
        phi_inc_o <= tone;
      end else if (step) begin
        sreg <= sreg << 1;
        bit_cnt <= bit_cnt - 1'b1;
        phi_inc_o <= tone;
      end else if (state_n == IDLE) phi_inc_o <= phi_idle;
    end
  end
endmodule

// File: tb/tb_fsk_phase_mod.sv
// tb_fsk_phase_mod: directed checks of tone sequence, strobes, handshake and reset for fsk_phase_mod.
module tb_fsk_phase_mod;
  import fsk_mod_pkg::*;
  localparam logic [31:0] F1_NEW = 32'h1234_5678;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [15:0] sps = 16'd4;
  logic [31:0] phi_f0 = FSK_PHI_F0, phi_f1 = FSK_PHI_F1, phi_idle = FSK_PHI_IDLE;
  logic [31:0] phi_inc_o;
  logic tx_active, bit_strobe;
  int tests = 0, fails = 0;
  fsk_phase_mod_if bus();
  fsk_phase_mod dut (
    .clk(clk), .reset_n(reset_n), .sps(sps), .phi_f0(phi_f0), .phi_f1(phi_f1),
    .phi_idle(phi_idle), .bus(bus), .phi_inc_o(phi_inc_o), .tx_active(tx_active),
    .bit_strobe(bit_strobe)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_phi"}, phi_inc_o, phi_idle);
    chk({tag, "_tx"}, {31'b0, tx_active}, 32'd0);
    chk({tag, "_rdy"}, {31'b0, bus.in_ready}, 32'd1);
  endtask
  // waits for in_ready, offers d, returns at the negedge of the first bit cycle
  task automatic start(input logic [7:0] d, input bit keep);
    bus.in_data = d;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 100 && !bus.in_ready; k++) @(negedge clk);
    chk("accept_wait", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
  endtask
  // checks lim cycles of word d at n clocks per bit; at cycle chg changes sps and phi_f1
  task automatic expect_word(input logic [7:0] d, input int n, input logic [31:0] f0,
                             input logic [31:0] f1, input int chg, input int lim);
    for (int i = 0; i < lim; i++) begin
      chk($sformatf("phi_%0d", i), phi_inc_o, d[7 - i / n] ? f1 : f0);
      chk($sformatf("strobe_%0d", i), {31'b0, bit_strobe}, {31'b0, i % n == 0});
      chk($sformatf("tx_%0d", i), {31'b0, tx_active}, 32'd1);
      chk($sformatf("rdy_%0d", i), {31'b0, bus.in_ready}, {31'b0, i == 8 * n - 1});
      if (i == chg) begin
        sps = 16'd2;
        phi_f1 = F1_NEW;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_phi", phi_inc_o, 32'd0);
    chk("rst_tx", {31'b0, tx_active}, 32'd0);
    chk("rst_rdy", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_strobe", {31'b0, bit_strobe}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");
    // single word 0xA5, sps=4
    start(8'hA5, 1'b0);
    expect_word(8'hA5, 4, FSK_PHI_F0, FSK_PHI_F1, -1, 32);
    chk_idle("a5_end");
    chk("a5_strobe_end", {31'b0, bit_strobe}, 32'd0);
    // idle tone follows phi_idle live
    phi_idle = 32'h2222_0000;
    @(negedge clk);
    chk_idle("idle_live");
    phi_idle = FSK_PHI_IDLE;
    @(negedge clk);
    // back-to-back 0xFF then 0x00, sps=3, no idle gap
    sps = 16'd3;
    start(8'hFF, 1'b1);
    bus.in_data = 8'h00;
    expect_word(8'hFF, 3, FSK_PHI_F0, FSK_PHI_F1, -1, 24);
    bus.in_valid = 1'b0;
    expect_word(8'h00, 3, FSK_PHI_F0, FSK_PHI_F1, -1, 24);
    chk_idle("b2b_end");
    // sps=0 behaves as 1
    sps = 16'd0;
    start(8'h81, 1'b0);
    expect_word(8'h81, 1, FSK_PHI_F0, FSK_PHI_F1, -1, 8);
    chk_idle("sps0_end");
    // mid-word control change only affects the next word
    sps = 16'd4;
    start(8'hA5, 1'b0);
    expect_word(8'hA5, 4, FSK_PHI_F0, FSK_PHI_F1, 9, 32);
    chk_idle("chg_gap");
    start(8'h3C, 1'b0);
    expect_word(8'h3C, 2, FSK_PHI_F0, F1_NEW, -1, 16);
    chk_idle("chg_end");
    phi_f1 = FSK_PHI_F1;
    sps = 16'd4;
    // reset mid-word aborts the word
    start(8'hC3, 1'b0);
    expect_word(8'hC3, 4, FSK_PHI_F0, FSK_PHI_F1, -1, 12);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_phi", phi_inc_o, 32'd0);
    chk("abort_tx", {31'b0, tx_active}, 32'd0);
    chk("abort_rdy", {31'b0, bus.in_ready}, 32'd0);
    chk("abort_strobe", {31'b0, bit_strobe}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("abort_rel");
    start(8'h5A, 1'b0);
    expect_word(8'h5A, 4, FSK_PHI_F0, FSK_PHI_F1, -1, 32);
    chk_idle("after_abort");
    // 0xF0: plain bits, or differentially encoded 1,0,1,0,0,0,0,0 when enabled
    sps = 16'd2;
    start(8'hF0, 1'b0);
`ifdef FSK_DIFF_ENC_EN
    expect_word(8'hA0, 2, FSK_PHI_F0, FSK_PHI_F1, -1, 16);
`else
    expect_word(8'hF0, 2, FSK_PHI_F0, FSK_PHI_F1, -1, 16);
`endif
    chk_idle("f0_end");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
